// File: rtl/uart_rx_core.sv
// UART receiver: 2-flop synchronizer, mid-bit sampling FSM, LSB-first reassembly, FIFO write port.
// Optional even-parity check enabled by defining UART_RX_PARITY_EN (adds parity_err port).
module uart_rx_core #(
    parameter int CLOCK_FREQUENCY = 100_000_000,
    parameter int BAUD_RATE       = 115200,
    parameter int WORD_WIDTH      = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx,
    input  logic                  full,
    output logic [WORD_WIDTH-1:0] dout,
    output logic                  we,
    output logic                  frame_err,
    output logic                  overrun,
`ifdef UART_RX_PARITY_EN
    output logic                  parity_err,
`endif
    output logic                  busy
);

    localparam int CLKS_PER_BIT = CLOCK_FREQUENCY / BAUD_RATE;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int IDX_W        = $clog2(WORD_WIDTH + 1);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(WORD_WIDTH - 1);

    generate
        if (CLKS_PER_BIT < 4) begin : g_bad_ratio
            $error("uart_rx_core: CLKS_PER_BIT must be at least 4");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_PARITY    = 3'd3,
        S_STOP      = 3'd4,
        S_WAIT_HIGH = 3'd5
    } state_t;

    state_t                  state_q;
    logic                    sync1_q;
    logic                    sync2_q;
    logic                    rx_s;
    logic [CNT_W-1:0]        cnt_q;
    logic [IDX_W-1:0]        idx_q;
    logic [WORD_WIDTH-1:0]   shift_q;
    logic [WORD_WIDTH-1:0]   dout_q;
    logic                    we_q;
    logic                    frame_err_q;
    logic                    overrun_q;
    logic                    busy_q;
`ifdef UART_RX_PARITY_EN
    logic                    parity_bad_q;
    logic                    parity_err_q;
`endif

    assign rx_s = sync2_q;

    // Two-flop synchronizer for the asynchronous rx pin; idles high.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
        end
    end

    // Receive FSM with registered strobes; strobes default low so each lasts one cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            shift_q      <= '0;
            dout_q       <= '0;
            we_q         <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
            busy_q       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bad_q <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            we_q        <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    if (!rx_s) begin
                        state_q <= S_START;
                        busy_q  <= 1'b1;
                    end else begin
                        busy_q  <= 1'b0;
                    end
                end
                S_START: begin
                    if (cnt_q == HALF_LAST) begin
                        cnt_q <= '0;
                        idx_q <= '0;
                        if (!rx_s) begin
                            state_q <= S_DATA;
                        end else begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q   <= '0;
                        // New bits enter at the MSB so the first bit ends up at bit 0.
                        shift_q <= {rx_s, shift_q[WORD_WIDTH-1:1]};
                        idx_q   <= idx_q + IDX_W'(1);
                        if (idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= S_PARITY;
`else
                            state_q <= S_STOP;
`endif
                        end else begin
                            state_q <= S_DATA;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q        <= '0;
                        parity_bad_q <= (^shift_q) ^ rx_s;
                        state_q      <= S_STOP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
`endif
                S_STOP: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q <= '0;
                        if (!rx_s) begin
                            frame_err_q <= 1'b1;
                            state_q     <= S_WAIT_HIGH;
                        end else begin
                            // Leaving at mid-stop-bit lets a back-to-back start bit be caught.
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
                            if (parity_bad_q) begin
                                parity_err_q <= 1'b1;
                            end else if (full) begin
                                overrun_q <= 1'b1;
                            end else begin
                                dout_q <= shift_q;
                                we_q   <= 1'b1;
                            end
`else
                            if (full) begin
                                overrun_q <= 1'b1;
                            end else begin
                                dout_q <= shift_q;
                                we_q   <= 1'b1;
                            end
`endif
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_WAIT_HIGH: begin
                    cnt_q <= '0;
                    if (rx_s) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= S_WAIT_HIGH;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign dout      = dout_q;
    assign we        = we_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = busy_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: directed scenarios plus random frames against an outcome model.
// Honors UART_RX_PARITY_EN the same way as the design.
module tb_uart_rx_core;

    localparam int CF   = 1_000_000;
    localparam int BR   = 100_000;
    localparam int W    = 8;
    localparam int CPB  = CF / BR;
    localparam int HALF = CPB / 2;
`ifdef UART_RX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int LAT = 3 + HALF + (W + 1 + PB) * CPB;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         rx = 1'b1;
    logic         full = 1'b0;
    logic [W-1:0] dout;
    logic         we;
    logic         frame_err;
    logic         overrun;
    logic         busy;
    logic         pe_mon;
`ifdef UART_RX_PARITY_EN
    logic         parity_err;
    assign pe_mon = parity_err;
`else
    assign pe_mon = 1'b0;
`endif

    uart_rx_core #(
        .CLOCK_FREQUENCY(CF),
        .BAUD_RATE(BR),
        .WORD_WIDTH(W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .rx(rx),
        .full(full),
        .dout(dout),
        .we(we),
        .frame_err(frame_err),
        .overrun(overrun),
`ifdef UART_RX_PARITY_EN
        .parity_err(parity_err),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: log every write with its cycle, count error pulses and overlapping strobes.
    logic [W-1:0] got_q[$];
    int           got_t[$];
    int           fe_n = 0, ov_n = 0, pe_n = 0, excl_bad = 0;
    always @(negedge clk) begin
        if (we) begin
            got_q.push_back(dout);
            got_t.push_back(cyc);
        end
        if (frame_err) fe_n <= fe_n + 1;
        if (overrun)   ov_n <= ov_n + 1;
        if (pe_mon)    pe_n <= pe_n + 1;
        if ((32'(we) + 32'(frame_err) + 32'(overrun) + 32'(pe_mon)) > 1) excl_bad <= excl_bad + 1;
    end

    // Reference model state: expected words with their start-edge cycles and expected error counts.
    logic [W-1:0] exp_q[$];
    int           exp_t[$];
    int           exp_fe = 0, exp_ov = 0, exp_pe = 0;
    int           fe_base = 0, ov_base = 0, pe_base = 0;
    int           checks = 0, errors = 0;

    task automatic chk(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bit_out(input logic b);
        rx = b;
        wait_cycles(CPB);
    endtask

    // Drives one frame; when track is set the model records the outcome the line protocol implies.
    task automatic send_frame(input logic [W-1:0] d, input logic stopb, input logic pflip, input bit track);
        int  t0;
        bit  bad_par;
        t0 = cyc;
        bad_par = (PB == 1) && pflip;
        if (track) begin
            if (!stopb)          exp_fe++;
            else if (bad_par)    exp_pe++;
            else if (full)       exp_ov++;
            else begin
                exp_q.push_back(d);
                exp_t.push_back(t0);
            end
        end
        bit_out(1'b0);
        for (int i = 0; i < W; i++) bit_out(d[i]);
        if (PB == 1) bit_out((^d) ^ pflip);
        bit_out(stopb);
        rx = 1'b1;
    endtask

    task automatic verify(input string tag);
        logic [W-1:0] g, e;
        int           t, t0, lat;
        chk({tag, "_nwords"}, got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g   = got_q.pop_front();
            t   = got_t.pop_front();
            e   = exp_q.pop_front();
            t0  = exp_t.pop_front();
            lat = t - t0;
            chk({tag, "_word"}, 32'(g), 32'(e));
            chk({tag, "_latency_ok"}, (lat >= LAT - 2 && lat <= LAT + 2) ? 1 : 0, 1);
        end
        got_q.delete(); got_t.delete(); exp_q.delete(); exp_t.delete();
        chk({tag, "_frame_err"}, fe_n - fe_base, exp_fe);
        chk({tag, "_overrun"}, ov_n - ov_base, exp_ov);
`ifdef UART_RX_PARITY_EN
        chk({tag, "_parity_err"}, pe_n - pe_base, exp_pe);
`endif
        chk({tag, "_exclusive"}, excl_bad, 0);
        chk({tag, "_busy_idle"}, 32'(busy), 0);
        fe_base = fe_n; ov_base = ov_n; pe_base = pe_n;
        exp_fe = 0; exp_ov = 0; exp_pe = 0;
    endtask

    initial begin
        int t0, rem, gap;
        logic [W-1:0] d;
        logic f;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_dout", 32'(dout), 0);
        chk("rst_we", 32'(we), 0);
        chk("rst_frame_err", 32'(frame_err), 0);
        chk("rst_overrun", 32'(overrun), 0);
        chk("rst_busy", 32'(busy), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        wait_cycles(5);

        // Single word
        send_frame(8'h55, 1'b1, 1'b0, 1'b1);
        wait_cycles(2 * CPB);
        verify("s1");

        // Back-to-back words, no idle bits
        send_frame(8'hA5, 1'b1, 1'b0, 1'b1);
        send_frame(8'h3C, 1'b1, 1'b0, 1'b1);
        wait_cycles(2 * CPB);
        verify("s2");

        // Start-bit glitch
        rx = 1'b0;
        wait_cycles(3);
        rx = 1'b1;
        wait_cycles(HALF + 3);
        chk("s3_busy_after_glitch", 32'(busy), 0);
        verify("s3");

        // Framing error, held break, then recovery
        send_frame(8'h00, 1'b0, 1'b0, 1'b1);
        rx = 1'b0;
        wait_cycles(40);
        rx = 1'b1;
        wait_cycles(20);
        send_frame(8'h81, 1'b1, 1'b0, 1'b1);
        wait_cycles(2 * CPB);
        verify("s4");

        // Overrun keeps the previous word
        send_frame(8'h12, 1'b1, 1'b0, 1'b1);
        wait_cycles(2 * CPB);
        verify("s5a");
        full = 1'b1;
        send_frame(8'h7E, 1'b1, 1'b0, 1'b1);
        wait_cycles(2 * CPB);
        verify("s5b");
        chk("s5_dout_held", 32'(dout), 32'h12);
        full = 1'b0;
        send_frame(8'h7E, 1'b1, 1'b0, 1'b1);
        wait_cycles(2 * CPB);
        verify("s5c");

        // Reset during data bit 4
        t0 = cyc;
        fork
            send_frame(8'hC3, 1'b1, 1'b0, 1'b0);
            begin
                wait_cycles(5 * CPB + 3);
                rst_n = 1'b0;
                @(posedge clk);
                @(negedge clk);
                chk("s6_rst_dout", 32'(dout), 0);
                chk("s6_rst_we", 32'(we), 0);
                chk("s6_rst_busy", 32'(busy), 0);
                @(posedge clk); #1;
                rst_n = 1'b1;
            end
        join
        rem = t0 + LAT + 3 - cyc;
        if (rem > 0) wait_cycles(rem);
        chk("s6_no_we_aborted", got_q.size(), 0);
        // Resynchronising on the tail of the aborted frame may produce a word; discard it.
        wait_cycles(3 * LAT);
        got_q.delete(); got_t.delete();
        fe_base = fe_n; ov_base = ov_n; pe_base = pe_n;
        send_frame(8'hC3, 1'b1, 1'b0, 1'b1);
        wait_cycles(2 * CPB);
        verify("s6");

`ifdef UART_RX_PARITY_EN
        // Parity mismatch drops the word
        send_frame(8'h01, 1'b1, 1'b1, 1'b1);
        wait_cycles(2 * CPB);
        verify("s7_parity");
`endif

        // Random frames with random gaps and random full
        for (int i = 0; i < 10; i++) begin
            d   = W'($urandom_range(0, 255));
            gap = $urandom_range(0, 12);
            f   = ($urandom_range(0, 3) == 0);
            full = f;
            send_frame(d, 1'b1, 1'(($urandom_range(0, 4) == 0) ? 1 : 0), 1'b1);
            if (gap > 0) wait_cycles(gap);
        end
        full = 1'b0;
        wait_cycles(2 * CPB);
        verify("rand");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
